control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opCode  input  4  opcode of current instruction.
REQ-005 Instr_Stage  input  2  pipeline stage: 00 fetch, 01 decode, 10 execute, 11 memory/write-back.
REQ-006 Instr_Fetch  output  1  fetch-stage enable.
REQ-007 Instr_Decode  output  1  decode-stage enable.
REQ-008 Instr_Exec  output  1  execute-stage enable.
REQ-009 Write_Back  output  1  register-file write enable.
REQ-010 MEM_Acc  output  1  memory-access enable.
REQ-011 Halt  output  1  processor halted, sticky.

Function
REQ-012 All outputs SHALL be registered: sampled opCode/Instr_Stage at rising edge N drive outputs from edge N until edge N+1; latency is 1 cycle.
REQ-013 Opcode map: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 SHL, 0111 SHR, 1000 LOAD, 1001 STORE, 1010 JMP, 1011 BEQ, 1100 MOV, 1101 LDI, 1110 NOP, 1111 HLT.
REQ-014 Stage 00 SHALL assert Instr_Fetch only, for every opcode.
REQ-015 Stage 01 SHALL assert Instr_Decode only, for every opcode.
REQ-016 Stage 10 SHALL assert Instr_Exec only, for every opcode except 1111.
REQ-017 Stage 10 with opCode 1111 SHALL set the Halt register and leave Instr_Exec at 0.
REQ-018 Stage 11 SHALL assert MEM_Acc for every opcode except 1111.
REQ-019 Stage 11 SHALL also assert Write_Back only for write-back opcodes 0000-1000, 1100, 1101.
REQ-020 Stage 11 SHALL leave Write_Back at 0 for 1001, 1010, 1011, 1110 and 1111.
REQ-021 Instr_Fetch, Instr_Decode, Instr_Exec and MEM_Acc SHALL be mutually exclusive in every cycle.
REQ-022 Write_Back SHALL be asserted only together with MEM_Acc.
REQ-023 Once set, Halt SHALL remain 1 regardless of inputs until rst.
REQ-024 While Halt=1, all other outputs SHALL be 0 from the edge Halt rises onward.
REQ-025 An opcode change without a stage change SHALL still update outputs on the next edge per the tables above.
REQ-026 No X/Z on outputs after reset; every input combination SHALL be fully decoded.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force all six outputs to 0, including clearing Halt.
REQ-028 With rst=1, clock edges SHALL have no effect.
REQ-029 After rst deasserts, the first rising edge SHALL load outputs from the current inputs.
REQ-030 Reset asserted mid-instruction SHALL abort that instruction with no residual state.

Verification
REQ-031 Scenario 1: opCode=0000, Instr_Stage=00 held one cycle after reset -> Instr_Fetch=1, all others 0.
REQ-032 Scenario 2: opCode=0000 with Instr_Stage 01, then 10, then 11, each held 10 ns (one period) -> Instr_Decode=1, then Instr_Exec=1, then MEM_Acc=1 and Write_Back=1, each alone otherwise.
REQ-033 Scenario 3: opCode=1001 (STORE), Instr_Stage=11 -> MEM_Acc=1, Write_Back=0.
REQ-034 Scenario 4: opCode=1111, Instr_Stage=10 -> next edge Halt=1, Instr_Exec=0.
REQ-035 Scenario 4 continued: then opCode=0000, Instr_Stage=00 -> Halt stays 1, Instr_Fetch stays 0.
REQ-036 Scenario 5: while halted, pulse rst between clock edges -> all outputs 0 immediately.
REQ-037 Scenario 5 continued: next edge with Instr_Stage=00 -> Instr_Fetch=1.
REQ-038 Scenario 6: sweep all 16 opcodes x 4 stages -> outputs match REQ-014..REQ-022 and the mutual-exclusion check holds every cycle.

Source files
------------

// File: rtl/control_unit.sv
// Pipeline control decoder: turns (opCode, Instr_Stage) into registered stage enables
// and keeps a sticky Halt that only reset clears.
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opCode,
   input  logic [1:0] Instr_Stage,
   output logic       Instr_Fetch,
   output logic       Instr_Decode,
   output logic       Instr_Exec,
   output logic       Write_Back,
   output logic       MEM_Acc,
   output logic       Halt
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      STG_FETCH  = 2'b00,
      STG_DECODE = 2'b01,
      STG_EXEC   = 2'b10,
      STG_MEM    = 2'b11
   } stage_e;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_NOT   = 4'b0101,
      OP_SHL   = 4'b0110,
      OP_SHR   = 4'b0111,
      OP_LOAD  = 4'b1000,
      OP_STORE = 4'b1001,
      OP_JMP   = 4'b1010,
      OP_BEQ   = 4'b1011,
      OP_MOV   = 4'b1100,
      OP_LDI   = 4'b1101,
      OP_NOP   = 4'b1110,
      OP_HLT   = 4'b1111
   } opcode_e;

   state_e  state_q, state_d;
   stage_e  stage;
   opcode_e op;

   logic fetch_q, fetch_d;
   logic decode_q, decode_d;
   logic exec_q, exec_d;
   logic wb_q, wb_d;
   logic mem_q, mem_d;
   logic writes_reg;

   // Every 2- and 4-bit code has an enum member, so these casts are lossless.
   assign stage = stage_e'(Instr_Stage);
   assign op    = opcode_e'(opCode);

   always_comb begin
      writes_reg = 1'b1;
      case (op)
         OP_STORE, OP_JMP, OP_BEQ, OP_NOP, OP_HLT: writes_reg = 1'b0;
         default:                                  writes_reg = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      fetch_d  = 1'b0;
      decode_d = 1'b0;
      exec_d   = 1'b0;
      wb_d     = 1'b0;
      mem_d    = 1'b0;
      case (state_q)
         ST_RUN: begin
            case (stage)
               STG_FETCH:  fetch_d  = 1'b1;
               STG_DECODE: decode_d = 1'b1;
               STG_EXEC: begin
                  if (op == OP_HLT) state_d = ST_HALT;
                  else              exec_d  = 1'b1;
               end
               STG_MEM: begin
                  if (op != OP_HLT) begin
                     mem_d = 1'b1;
                     wb_d  = writes_reg;
                  end
               end
               default: ;
            endcase
         end
         // Halted: all enables stay low until reset.
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         fetch_q  <= 1'b0;
         decode_q <= 1'b0;
         exec_q   <= 1'b0;
         wb_q     <= 1'b0;
         mem_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fetch_q  <= fetch_d;
         decode_q <= decode_d;
         exec_q   <= exec_d;
         wb_q     <= wb_d;
         mem_q    <= mem_d;
      end
   end

   assign Instr_Fetch  = fetch_q;
   assign Instr_Decode = decode_q;
   assign Instr_Exec   = exec_q;
   assign Write_Back   = wb_q;
   assign MEM_Acc      = mem_q;
   assign Halt         = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: vector table sweep plus halt/reset sequences.
module tb_control_unit;

   logic       clk;
   logic       rst;
   logic [3:0] opCode;
   logic [1:0] Instr_Stage;
   logic       Instr_Fetch, Instr_Decode, Instr_Exec, Write_Back, MEM_Acc, Halt;

   control_unit dut (
      .clk          (clk),
      .rst          (rst),
      .opCode       (opCode),
      .Instr_Stage  (Instr_Stage),
      .Instr_Fetch  (Instr_Fetch),
      .Instr_Decode (Instr_Decode),
      .Instr_Exec   (Instr_Exec),
      .Write_Back   (Write_Back),
      .MEM_Acc      (MEM_Acc),
      .Halt         (Halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view: {Halt, Fetch, Decode, Exec, WriteBack, MemAcc}
   logic [5:0] outs;
   assign outs = {Halt, Instr_Fetch, Instr_Decode, Instr_Exec, Write_Back, MEM_Acc};

   localparam logic [5:0] E_NONE  = 6'b000000;
   localparam logic [5:0] E_FETCH = 6'b010000;
   localparam logic [5:0] E_DEC   = 6'b001000;
   localparam logic [5:0] E_EXEC  = 6'b000100;
   localparam logic [5:0] E_MEMWB = 6'b000011;
   localparam logic [5:0] E_MEM   = 6'b000001;
   localparam logic [5:0] E_HALT  = 6'b100000;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [3:0] op;
      logic [1:0] stage;
      logic [5:0] exp;
      string      name;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];
   string      name_q[$];

   function automatic logic [5:0] expect_of(logic [3:0] op, logic [1:0] stage);
      logic wb_op;
      wb_op = (op <= 4'd8) || (op == 4'd12) || (op == 4'd13);
      case (stage)
         2'd0:    return E_FETCH;
         2'd1:    return E_DEC;
         2'd2:    return (op == 4'd15) ? E_HALT : E_EXEC;
         default: return (op == 4'd15) ? E_NONE : (wb_op ? E_MEMWB : E_MEM);
      endcase
   endfunction

   task automatic check(string name, logic [5:0] act, logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic apply(logic [3:0] op, logic [1:0] stage, logic [5:0] exp, string name);
      opCode      = op;
      Instr_Stage = stage;
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic settle();
      logic [5:0] e;
      string      n;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, outs, e);
      end
   endtask

   task automatic drive(logic [3:0] op, logic [1:0] stage, logic [5:0] exp, string name);
      @(negedge clk);
      apply(op, stage, exp, name);
      settle();
   endtask

   // Structural invariants sampled every cycle, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (($countones({Instr_Fetch, Instr_Decode, Instr_Exec, MEM_Acc}) > 1) ||
             (Write_Back && !MEM_Acc) ||
             (Halt && (|outs[4:0]))) begin
            errors++;
            $display("FAIL invariant: got %b expected one-hot enables, WB only with MEM, quiet when halted", outs);
         end
      end
   end

   initial begin
      // Hand-written entries for the named scenarios, then the full sweep with
      // the halting combination deferred to the sequences below.
      vecs.push_back('{4'd0, 2'd0, E_FETCH, "s1_fetch"});
      vecs.push_back('{4'd0, 2'd1, E_DEC,   "s2_decode"});
      vecs.push_back('{4'd0, 2'd2, E_EXEC,  "s2_exec"});
      vecs.push_back('{4'd0, 2'd3, E_MEMWB, "s2_mem_wb"});
      vecs.push_back('{4'd9, 2'd3, E_MEM,   "s3_store"});
      for (int unsigned s = 0; s < 4; s++) begin
         for (int unsigned o = 0; o < 16; o++) begin
            if (!(s == 2 && o == 15))
               vecs.push_back('{4'(o), 2'(s), expect_of(4'(o), 2'(s)),
                                $sformatf("sweep_op%0d_st%0d", o, s)});
         end
      end

      rst         = 1'b1;
      opCode      = 4'd0;
      Instr_Stage = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", outs, E_NONE);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      foreach (vecs[i])
         drive(vecs[i].op, vecs[i].stage, vecs[i].exp, vecs[i].name);

      // Stage 11 with HLT: no memory access, no halt.
      drive(4'd15, 2'd3, E_NONE, "hlt_stage3");

      // Halt entry and stickiness against every stage.
      drive(4'd15, 2'd2, E_HALT, "s4_halt");
      drive(4'd0,  2'd0, E_HALT, "s4_sticky_fetch");
      drive(4'd0,  2'd3, E_HALT, "s4_sticky_mem");
      drive(4'd3,  2'd1, E_HALT, "s4_sticky_decode");

      // Async reset pulse between edges while halted.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("s5_async_clear", outs, E_NONE);
      #1;
      rst = 1'b0;
      apply(4'd0, 2'd0, E_FETCH, "s5_first_edge");
      settle();

      // Reset mid-instruction, held across an edge, then a clean restart.
      drive(4'd8, 2'd2, E_EXEC, "mid_exec");
      @(negedge clk);
      rst         = 1'b1;
      Instr_Stage = 2'd1;
      #1;
      check("mid_abort", outs, E_NONE);
      @(posedge clk);
      #1;
      check("rst_ignores_edge", outs, E_NONE);
      @(negedge clk);
      rst = 1'b0;
      apply(4'd13, 2'd3, E_MEMWB, "post_rst_ldi_mem");
      settle();
      drive(4'd10, 2'd3, E_MEM, "jmp_mem");

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
